// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stages: bus widths, the one-hot
// load_op bit positions, the stall vector indices and the packed layout
// of the execute-to-memory bus.
package pipeline_pkg;

    localparam int ES_TO_MS_BUS_WD = 175;
    localparam int MS_TO_ES_BUS_WD = 38;
    localparam int MS_TO_WS_BUS_WD = 166;

    localparam int LD_B  = 0;
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;
    localparam int LL_W  = 5;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    typedef struct packed {
        logic [63:0] csr_bus;
        logic [5:0]  load_op;
        logic [2:0]  store_op;
        logic        reg_we;
        logic [4:0]  dest;
        logic [31:0] es_result;
        logic [31:0] pc;
        logic [31:0] inst;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: picks the byte or halfword addressed by the low address
// bits out of a 32-bit SRAM word and sign- or zero-extends it. Word loads
// (and ll.w) and non-loads get the raw word; misaligned low bits are ignored.
module load_align
    import pipeline_pkg::*;
(
    input  logic [5:0]  load_op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and extend it according to the load kind.
    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        aligned  = rdata;
        if (load_op[LD_B]) begin
            aligned = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_op[LD_BU]) begin
            aligned = {24'd0, byte_sel};
        end else if (load_op[LD_H]) begin
            aligned = {{16{half_sel[15]}}, half_sel};
        end else if (load_op[LD_HU]) begin
            aligned = {16'd0, half_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage. Registers the execute-to-memory bus, aligns load
// data from the synchronous data SRAM, and keeps the SRAM word in a
// one-entry buffer while stalled so a load's data survives the stall.
module mem_stage
    import pipeline_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [5:0]                 stall,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus
);

    es_to_ms_t   es_to_ms_bus_r;
    logic [31:0] rbuf;
    logic        rbuf_v;
    logic [31:0] raw_rdata;
    logic [31:0] load_data;
    logic [31:0] ms_result;
    logic        is_load;
    logic        unused_ok;

    assign is_load = |es_to_ms_bus_r.load_op;

    // Pipeline register: reset and flush kill, an execute-only stall inserts
    // a bubble, a free execute stage advances, otherwise the entry holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            es_to_ms_bus_r <= '0;
        end else if (flush) begin
            es_to_ms_bus_r <= '0;
        end else if (stall[STALL_EX] && !stall[STALL_MEM]) begin
            es_to_ms_bus_r <= '0;
        end else if (!stall[STALL_EX]) begin
            es_to_ms_bus_r <= es_to_ms_t'(es_to_ms_bus);
        end
    end

    // Capture the SRAM word on the first stalled cycle of a load; the SRAM
    // only presents it once, so later cycles must replay the buffered copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rbuf   <= '0;
            rbuf_v <= 1'b0;
        end else if (flush || !stall[STALL_MEM]) begin
            rbuf_v <= 1'b0;
        end else if (is_load && !rbuf_v) begin
            rbuf   <= data_sram_rdata;
            rbuf_v <= 1'b1;
        end
    end

    assign raw_rdata = rbuf_v ? rbuf : data_sram_rdata;

    load_align u_load_align (
        .load_op (es_to_ms_bus_r.load_op),
        .off     (es_to_ms_bus_r.es_result[1:0]),
        .rdata   (raw_rdata),
        .aligned (load_data)
    );

    assign ms_result = is_load ? load_data : es_to_ms_bus_r.es_result;

    assign ms_to_es_bus = {es_to_ms_bus_r.reg_we, es_to_ms_bus_r.dest, ms_result};

    assign ms_to_ws_bus = {es_to_ms_bus_r.csr_bus,
                           es_to_ms_bus_r.reg_we,
                           es_to_ms_bus_r.dest,
                           ms_result,
                           es_to_ms_bus_r.pc,
                           es_to_ms_bus_r.inst};

    // store_op and the other stages' stall bits travel through this stage
    // without affecting it.
    assign unused_ok = ^{stall[5], stall[2:0], es_to_ms_bus_r.store_op};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios from the stage's
// behaviour plus a randomized run against a high-level reference model.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic [5:0]   stall;
    logic [174:0] es_to_ms_bus;
    logic [31:0]  data_sram_rdata;
    logic [37:0]  ms_to_es_bus;
    logic [165:0] ms_to_ws_bus;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [5:0] ST_NONE = 6'b000000;
    localparam logic [5:0] ST_BOTH = 6'b011000;
    localparam logic [5:0] ST_EX   = 6'b001000;
    localparam logic [5:0] ST_MEM  = 6'b010000;

    localparam logic [5:0] OP_NONE = 6'b000000;
    localparam logic [5:0] OP_LDB  = 6'b000001;
    localparam logic [5:0] OP_LDH  = 6'b000010;
    localparam logic [5:0] OP_LDW  = 6'b000100;
    localparam logic [5:0] OP_LDBU = 6'b001000;
    localparam logic [5:0] OP_LDHU = 6'b010000;
    localparam logic [5:0] OP_LLW  = 6'b100000;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .stall           (stall),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_es_bus    (ms_to_es_bus),
        .ms_to_ws_bus    (ms_to_ws_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [174:0] make_bus(input logic [63:0] csr, input logic [5:0] lop,
                                              input logic [2:0] sop, input logic we,
                                              input logic [4:0] dest, input logic [31:0] res,
                                              input logic [31:0] pc, input logic [31:0] inst);
        return {csr, lop, sop, we, dest, res, pc, inst};
    endfunction

    // Reference load result computed arithmetically from the address and word.
    function automatic logic [31:0] ref_result(input logic [5:0] lop, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        longint unsigned word_v = longint'(rdata);
        longint unsigned off    = longint'(addr) % 4;
        longint unsigned byte_v = (word_v >> (8 * off)) % 256;
        longint unsigned half_v = (word_v >> (16 * (off / 2))) % 65536;
        longint          s;
        logic [63:0]     r;
        case (lop)
            OP_LDB:  s = (byte_v >= 128) ? longint'(byte_v) - 256 : longint'(byte_v);
            OP_LDBU: s = longint'(byte_v);
            OP_LDH:  s = (half_v >= 32768) ? longint'(half_v) - 65536 : longint'(half_v);
            OP_LDHU: s = longint'(half_v);
            OP_LDW, OP_LLW: s = longint'(word_v);
            default: s = longint'(addr);
        endcase
        r = s;
        return r[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b1;
        stall = ST_NONE;
        es_to_ms_bus = make_bus({$urandom, $urandom}, OP_LDW, 3'd0, 1'b1, 5'd7,
                                $urandom, $urandom, $urandom);
        data_sram_rdata = $urandom;
        step();
        settle();
        tests_run++;
        if (ms_to_ws_bus !== 166'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ws_bus got=%h want=0", ms_to_ws_bus);
        end
        tests_run++;
        if (ms_to_es_bus !== 38'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_es_bus got=%h want=0", ms_to_es_bus);
        end
        reset = 1'b0;
        flush = 1'b0;
        es_to_ms_bus = '0;
        step();
    endtask

    task automatic test_ld_b_sign();
        logic [63:0] csr = {$urandom, $urandom};
        es_to_ms_bus = make_bus(csr, OP_LDB, 3'd0, 1'b1, 5'd9, 32'h1000_0003, 32'h1c00_0010, 32'h2800_0000);
        stall = ST_NONE;
        step();
        data_sram_rdata = 32'h80AB_CDEF;
        settle();
        tests_run++;
        if (ms_to_ws_bus[95:64] !== 32'hFFFF_FF80) begin
            tests_failed++;
            $display("[TB] FAIL ld_b_result got=%h want=ffffff80", ms_to_ws_bus[95:64]);
        end
        tests_run++;
        if (ms_to_es_bus !== {1'b1, 5'd9, 32'hFFFF_FF80}) begin
            tests_failed++;
            $display("[TB] FAIL ld_b_fwd got=%h want=%h", ms_to_es_bus, {1'b1, 5'd9, 32'hFFFF_FF80});
        end
    endtask

    task automatic test_ld_hu_zero();
        es_to_ms_bus = make_bus({$urandom, $urandom}, OP_LDHU, 3'd0, 1'b1, 5'd12,
                                32'h2000_0002, 32'h1c00_0020, 32'h2a40_0000);
        stall = ST_NONE;
        step();
        data_sram_rdata = 32'h8001_1234;
        settle();
        tests_run++;
        if (ms_to_ws_bus[95:64] !== 32'h0000_8001) begin
            tests_failed++;
            $display("[TB] FAIL ld_hu_result got=%h want=00008001", ms_to_ws_bus[95:64]);
        end
    endtask

    task automatic test_stall_hold();
        logic [63:0] csr = {$urandom, $urandom};
        logic [165:0] want;
        es_to_ms_bus = make_bus(csr, OP_LDW, 3'd0, 1'b1, 5'd3, 32'h3000_0000, 32'h1c00_0030, 32'h2880_0000);
        stall = ST_NONE;
        step();
        want = {csr, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h1c00_0030, 32'h2880_0000};
        data_sram_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            stall = (c < 3) ? ST_BOTH : ST_NONE;
            if (c > 0) data_sram_rdata = 32'h0;
            es_to_ms_bus = make_bus({$urandom, $urandom}, OP_NONE, 3'd0, 1'b1, 5'd1,
                                    $urandom, $urandom, $urandom);
            settle();
            tests_run++;
            if (ms_to_ws_bus !== want) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold_c%0d got=%h want=%h", c, ms_to_ws_bus, want);
            end
            if (c < 3) step();
        end
        es_to_ms_bus = '0;
        step();
    endtask

    task automatic test_bubble();
        es_to_ms_bus = make_bus({$urandom, $urandom}, OP_LDW, 3'd0, 1'b1, 5'd4,
                                $urandom, $urandom, $urandom);
        stall = ST_EX;
        step();
        stall = ST_NONE;
        settle();
        tests_run++;
        if (ms_to_ws_bus !== 166'd0) begin
            tests_failed++;
            $display("[TB] FAIL bubble_ws got=%h want=0", ms_to_ws_bus);
        end
        tests_run++;
        if (ms_to_es_bus[37] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bubble_we got=%b want=0", ms_to_es_bus[37]);
        end
        es_to_ms_bus = '0;
        step();
    endtask

    task automatic test_flush();
        es_to_ms_bus = make_bus({$urandom, $urandom}, OP_LDW, 3'd0, 1'b1, 5'd6,
                                32'h4000_0000, $urandom, $urandom);
        stall = ST_NONE;
        step();
        data_sram_rdata = 32'h1111_1111;
        stall = ST_BOTH;
        step();
        data_sram_rdata = 32'h0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        tests_run++;
        if (ms_to_ws_bus !== 166'd0) begin
            tests_failed++;
            $display("[TB] FAIL flush_ws got=%h want=0", ms_to_ws_bus);
        end
        tests_run++;
        if (ms_to_es_bus !== 38'd0) begin
            tests_failed++;
            $display("[TB] FAIL flush_es got=%h want=0", ms_to_es_bus);
        end
        // Memory stall stays up while a fresh load enters: it must see live data.
        stall = ST_MEM;
        es_to_ms_bus = make_bus({$urandom, $urandom}, OP_LDW, 3'd0, 1'b1, 5'd8,
                                32'h4000_0004, $urandom, $urandom);
        step();
        data_sram_rdata = 32'h2222_2222;
        stall = ST_NONE;
        settle();
        tests_run++;
        if (ms_to_ws_bus[95:64] !== 32'h2222_2222) begin
            tests_failed++;
            $display("[TB] FAIL flush_live_rdata got=%h want=22222222", ms_to_ws_bus[95:64]);
        end
        es_to_ms_bus = '0;
        step();
    endtask

    task automatic test_alu_pass();
        logic [63:0] csr = {$urandom, $urandom};
        es_to_ms_bus = make_bus(csr, OP_NONE, 3'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0040, 32'h0010_0000);
        stall = ST_NONE;
        step();
        data_sram_rdata = $urandom;
        settle();
        tests_run++;
        if (ms_to_es_bus !== {1'b1, 5'd5, 32'h1234_5678}) begin
            tests_failed++;
            $display("[TB] FAIL alu_fwd got=%h want=%h", ms_to_es_bus, {1'b1, 5'd5, 32'h1234_5678});
        end
        tests_run++;
        if (ms_to_ws_bus[165:102] !== csr) begin
            tests_failed++;
            $display("[TB] FAIL alu_csr got=%h want=%h", ms_to_ws_bus[165:102], csr);
        end
    endtask

    // Random instruction stream with random memory stalls; each instruction's
    // expected outputs follow from its fields and the word the SRAM gave in
    // its first cycle in the stage.
    task automatic test_random();
        logic [5:0]   ops [7] = '{OP_NONE, OP_LDB, OP_LDH, OP_LDW, OP_LDBU, OP_LDHU, OP_LLW};
        logic [63:0]  csr;
        logic [5:0]   lop;
        logic [2:0]   sop;
        logic         we;
        logic [4:0]   dest;
        logic [31:0]  res, pc, inst, first;
        logic [31:0]  exp_res;
        logic [165:0] want_ws;
        logic [37:0]  want_es;
        int           stall_cycles;
        csr  = {$urandom, $urandom};
        lop  = ops[$urandom_range(0, 6)];
        sop  = (lop == OP_NONE) ? 3'($urandom) : 3'd0;
        we   = (sop != 3'd0) ? 1'b0 : 1'b1;
        dest = 5'($urandom);
        res  = $urandom; pc = $urandom; inst = $urandom;
        es_to_ms_bus = make_bus(csr, lop, sop, we, dest, res, pc, inst);
        stall = ST_NONE;
        step();
        for (int i = 0; i < 40; i++) begin
            first = $urandom;
            data_sram_rdata = first;
            exp_res = ref_result(lop, res, first);
            want_ws = {csr, we, dest, exp_res, pc, inst};
            want_es = {we, dest, exp_res};
            stall_cycles = $urandom_range(0, 3);
            for (int c = 0; c <= stall_cycles; c++) begin
                stall = (c < stall_cycles) ? ST_BOTH : ST_NONE;
                if (c > 0) data_sram_rdata = $urandom;
                settle();
                tests_run++;
                if (ms_to_ws_bus !== want_ws) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_ws i=%0d c=%0d got=%h want=%h", i, c, ms_to_ws_bus, want_ws);
                end
                tests_run++;
                if (ms_to_es_bus !== want_es) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_es i=%0d c=%0d got=%h want=%h", i, c, ms_to_es_bus, want_es);
                end
                if (c < stall_cycles) begin
                    es_to_ms_bus = make_bus({$urandom, $urandom}, ops[$urandom_range(0, 6)], 3'd0,
                                            1'b1, 5'($urandom), $urandom, $urandom, $urandom);
                    step();
                end
            end
            csr  = {$urandom, $urandom};
            lop  = ops[$urandom_range(0, 6)];
            sop  = (lop == OP_NONE) ? 3'($urandom) : 3'd0;
            we   = (sop != 3'd0) ? 1'b0 : 1'b1;
            dest = 5'($urandom);
            res  = $urandom; pc = $urandom; inst = $urandom;
            es_to_ms_bus = make_bus(csr, lop, sop, we, dest, res, pc, inst);
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        stall = ST_NONE;
        es_to_ms_bus = '0;
        data_sram_rdata = '0;
        step();
        test_reset();
        test_ld_b_sign();
        test_ld_hu_zero();
        test_stall_hold();
        test_bubble();
        test_flush();
        test_alu_pass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
